bus_arbiter: RTL

- Round-robin controller that shares one broadcast bus among `devices` FIFO-buffered terminals.
- Each terminal's source FIFO reports pending data. The arbiter grants one source, pops one word from it and delivers it to the destination FIFO(s) addressed in the word's ID field.
- Sits between the per-device source FIFOs (first-word-fall-through head) and the per-device destination FIFOs.

---
 rtl/bus_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter sharing one broadcast bus among FIFO-buffered devices
//
// Purpose: picks one pending source FIFO in round-robin order, pops its head
// word and pushes it to the destination FIFO(s) named by the word's top byte.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous, active-high reset
//   pndng_i  - per-device "source FIFO non-empty"
//   dato_i   - concatenated source FIFO head words, device d at [d*width +: width]
//   full_i   - per-device "destination FIFO full"
//   pop_o    - one-hot pop strobe to the granted source FIFO
//   push_o   - push strobes to destination FIFOs
//   dato_o   - bus data presented to all destination FIFOs
//   grant_o  - one-hot current bus owner
//   busy_o   - transfer in progress
//   err_o    - one-cycle pulse when a word carries an invalid destination ID

module bus_arbiter #(
    parameter int         width   = 16,
    parameter int         devices = 4,
    parameter logic [7:0] bcast   = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [devices-1:0]         pndng_i,
    input  logic [devices*width-1:0]   dato_i,
    input  logic [devices-1:0]         full_i,
    output logic [devices-1:0]         pop_o,
    output logic [devices-1:0]         push_o,
    output logic [width-1:0]           dato_o,
    output logic [devices-1:0]         grant_o,
    output logic                       busy_o,
    output logic                       err_o
);

    localparam int IW = $clog2(devices);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_DELIVER
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IW-1:0]      r_sel;
    logic [IW-1:0]      w_sel_next;
    logic [IW-1:0]      r_last;
    logic [width-1:0]   r_data;

    logic [width-1:0]   w_heads [devices];
    logic [devices-1:0] w_one;
    logic [devices-1:0] w_sel_onehot;
    logic [7:0]         w_id;
    logic               w_id_local;
    logic               w_id_valid;
    logic [devices-1:0] w_mask;
    logic [IW-1:0]      w_rr_base;
    logic [IW-1:0]      w_rr_sel;
    logic               w_exit;

    for (genvar g = 0; g < devices; g++) begin : g_heads
        assign w_heads[g] = dato_i[g*width +: width];
    end

    assign w_one        = {{(devices-1){1'b0}}, 1'b1};
    assign w_sel_onehot = w_one << r_sel;
    assign w_id         = r_data[width-1 -: 8];
    assign w_id_local   = ({1'b0, w_id} < 9'(devices));
    assign w_id_valid   = w_id_local || (w_id == bcast);

    always_comb begin
        w_mask = '0;
        if (w_id_local) begin
            w_mask = w_one << w_id;
        end else if (w_id == bcast) begin
            w_mask = ~w_sel_onehot;
        end
    end

    // On a DELIVER exit the owner being released becomes the new "last",
    // so the next search starts just after it in the same cycle.
    assign w_rr_base = (r_state == ST_DELIVER) ? r_sel : r_last;

    always_comb begin
        int v_idx;
        logic v_found;
        v_found  = 1'b0;
        v_idx    = 0;
        w_rr_sel = '0;
        for (int i = 1; i <= devices; i++) begin
            v_idx = (int'(w_rr_base) + i) % devices;
            if (!v_found && pndng_i[v_idx]) begin
                v_found  = 1'b1;
                w_rr_sel = IW'(v_idx);
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_sel_next = r_sel;
        w_exit     = 1'b0;
        pop_o      = '0;
        push_o     = '0;
        grant_o    = '0;
        dato_o     = '0;
        busy_o     = 1'b0;
        err_o      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|pndng_i) begin
                    w_sel_next = w_rr_sel;
                    w_next     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                grant_o = w_sel_onehot;
                pop_o   = w_sel_onehot;
                busy_o  = 1'b1;
                w_next  = ST_DELIVER;
            end
            ST_DELIVER: begin
                grant_o = w_sel_onehot;
                dato_o  = r_data;
                busy_o  = 1'b1;
                if (!w_id_valid) begin
                    err_o  = 1'b1;
                    w_exit = 1'b1;
                end else if ((w_mask & full_i) == '0) begin
                    push_o = w_mask;
                    w_exit = 1'b1;
                end
                if (w_exit) begin
                    if (|pndng_i) begin
                        w_sel_next = w_rr_sel;
                        w_next     = ST_GRANT;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_last  <= IW'(devices - 1);
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            r_sel   <= w_sel_next;
            if (r_state == ST_GRANT) begin
                r_data <= w_heads[r_sel];
            end
            if (w_exit) begin
                r_last <= r_sel;
            end
        end
    end

endmodule
